instr_decode_ctrl: RTL and testbench

Multi-cycle decoder and control sequencer on the consumer side of the instruction fetch unit.
- Latches the 32-bit instruction the fetch unit presents.
- Decodes a MIPS subset and sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives back to the fetch unit the PC-update strobe and the redirect flags Jump, JumpReg, Branch and InvZero, plus TargetInstr and imm16.
- Drives register-file, ALU and data-memory controls, with a ready handshake on data memory.

---
 rtl/instr_decode_ctrl_if.sv | 37 +++
 rtl/instr_decode_ctrl.sv | 176 +++++++++++++++++
 tb/tb_instr_decode_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_ctrl_if.sv
// Decoder <-> fetch/datapath bundle: instruction word and memory ready in, sequencing controls out.
// The fetch side (or a bench) takes the master modport; the decoder takes the slave modport.
interface instr_decode_ctrl_if;
    logic [31:0] Instruction;
    logic        mem_ready;
    logic        pc_advance;
    logic        Jump;
    logic        JumpReg;
    logic        Branch;
    logic        InvZero;
    logic [25:0] TargetInstr;
    logic [15:0] imm16;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd_sel;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        ALUSrc;
    logic        LinkWrite;
    logic [2:0]  ALUctrl;
    logic        illegal;
    logic        mem_timeout;

    modport master (
        output Instruction, mem_ready,
        input  pc_advance, Jump, JumpReg, Branch, InvZero, TargetInstr, imm16, rs, rt, rd_sel,
               RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, LinkWrite, ALUctrl, illegal, mem_timeout
    );

    modport slave (
        input  Instruction, mem_ready,
        output pc_advance, Jump, JumpReg, Branch, InvZero, TargetInstr, imm16, rs, rt, rd_sel,
               RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, LinkWrite, ALUctrl, illegal, mem_timeout
    );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle MIPS-subset decoder and FETCH/DECODE/EXEC/MEM/WB sequencer behind the fetch unit.
// Controls are combinational from state and the latched IR; illegal and mem_timeout are sticky.
module instr_decode_ctrl #(
    parameter int LINK_REG     = 31,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    instr_decode_ctrl_if.slave bus
);
    // state  | meaning
    // FETCH  | instruction presented; IR loads on exit
    // DECODE | classify; j/jal/jr/illegal retire here
    // EXEC   | ALU setup; beq/bne retire here
    // MEM    | lw/sw access, waits on mem_ready
    // WB     | register write-back, retire
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    state_t        state, state_nxt;
    logic [31:0]   ir;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          illegal_q, timeout_q;
    logic          illegal_set, timeout_set;
    logic [5:0]    op, funct;
    logic          is_r, is_r_alu, is_jr, is_jump, is_branch, is_mem, supported;

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign is_r      = (op == OP_RTYPE);
    assign is_r_alu  = is_r && (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT);
    assign is_jr     = is_r && (funct == FN_JR);
    assign is_jump   = (op == OP_J) || (op == OP_JAL);
    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign is_mem    = (op == OP_LW) || (op == OP_SW);
    assign supported = is_r_alu || is_branch || is_mem || (op == OP_ADDI) || (op == OP_XORI);

    assign bus.TargetInstr = ir[25:0];
    assign bus.imm16       = ir[15:0];
    assign bus.rs          = ir[25:21];
    assign bus.rt          = ir[20:16];
    // Flags show up in the same cycle that raises them, then hold until reset.
    assign bus.illegal     = illegal_q | illegal_set;
    assign bus.mem_timeout = timeout_q | timeout_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            ir        <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == FETCH) ir <= bus.Instruction;
            if (illegal_set) illegal_q <= 1'b1;
            if (timeout_set) timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        illegal_set    = 1'b0;
        timeout_set    = 1'b0;
        bus.pc_advance = 1'b0;
        bus.Jump       = 1'b0;
        bus.JumpReg    = 1'b0;
        bus.Branch     = 1'b0;
        bus.InvZero    = 1'b0;
        bus.rd_sel     = '0;
        bus.RegWrite   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.MemToReg   = 1'b0;
        bus.ALUSrc     = 1'b0;
        bus.LinkWrite  = 1'b0;
        bus.ALUctrl    = 3'b000;
        case (state)
            FETCH: state_nxt = DECODE;
            DECODE: begin
                if (is_jump) begin
                    bus.Jump       = 1'b1;
                    bus.pc_advance = 1'b1;
                    if (op == OP_JAL) begin
                        bus.LinkWrite = 1'b1;
                        bus.RegWrite  = 1'b1;
                        bus.rd_sel    = 5'(LINK_REG);
                    end
                    state_nxt = FETCH;
                end else if (is_jr) begin
                    bus.JumpReg    = 1'b1;
                    bus.pc_advance = 1'b1;
                    state_nxt      = FETCH;
                end else if (supported) begin
                    state_nxt = EXEC;
                end else begin
                    illegal_set    = 1'b1;
                    bus.pc_advance = 1'b1;
                    state_nxt      = FETCH;
                end
            end
            EXEC: begin
                if (is_r) begin
                    case (funct)
                        FN_SUB:  bus.ALUctrl = 3'b001;
                        FN_SLT:  bus.ALUctrl = 3'b010;
                        default: bus.ALUctrl = 3'b000;
                    endcase
                end else if (op == OP_XORI) begin
                    bus.ALUctrl = 3'b011;
                    bus.ALUSrc  = 1'b1;
                end else if (is_branch) begin
                    bus.ALUctrl = 3'b001;
                end else begin
                    bus.ALUSrc = 1'b1;
                end
                if (is_branch) begin
                    bus.Branch     = 1'b1;
                    bus.InvZero    = (op == OP_BNE);
                    bus.pc_advance = 1'b1;
                    state_nxt      = FETCH;
                end else if (is_mem) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                bus.MemRead  = (op == OP_LW);
                bus.MemWrite = (op == OP_SW);
                if (bus.mem_ready) begin
                    wait_cnt_nxt = '0;
                    if (op == OP_SW) begin
                        bus.pc_advance = 1'b1;
                        state_nxt      = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (wait_cnt == CW'(MEM_WAIT_MAX - 1)) begin
                    // This wait would bring the count to the limit: abandon the access.
                    wait_cnt_nxt   = '0;
                    timeout_set    = 1'b1;
                    bus.pc_advance = 1'b1;
                    state_nxt      = FETCH;
                end else begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            WB: begin
                bus.RegWrite   = 1'b1;
                bus.pc_advance = 1'b1;
                bus.MemToReg   = (op == OP_LW);
                bus.rd_sel     = is_r ? ir[15:11] : ir[20:16];
                state_nxt      = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl: per-cycle control vectors checked against hand-computed values.
module tb_instr_decode_ctrl;
    localparam logic [12:0] C_PCA = 13'h1000;
    localparam logic [12:0] C_J   = 13'h0800;
    localparam logic [12:0] C_JR  = 13'h0400;
    localparam logic [12:0] C_BR  = 13'h0200;
    localparam logic [12:0] C_INV = 13'h0100;
    localparam logic [12:0] C_RW  = 13'h0080;
    localparam logic [12:0] C_MR  = 13'h0040;
    localparam logic [12:0] C_MW  = 13'h0020;
    localparam logic [12:0] C_M2R = 13'h0010;
    localparam logic [12:0] C_SRC = 13'h0008;
    localparam logic [12:0] C_LNK = 13'h0004;
    localparam logic [12:0] C_ILL = 13'h0002;
    localparam logic [12:0] C_TO  = 13'h0001;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [12:0] f;

    instr_decode_ctrl_if bus ();

    instr_decode_ctrl #(.LINK_REG(31), .MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] ctl();
        return {bus.pc_advance, bus.Jump, bus.JumpReg, bus.Branch, bus.InvZero, bus.RegWrite,
                bus.MemRead, bus.MemWrite, bus.MemToReg, bus.ALUSrc, bus.LinkWrite,
                bus.illegal, bus.mem_timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample mid-cycle, then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic [12:0] e_ctl, input logic [2:0] e_alu,
                       input logic [4:0] e_rd);
        @(negedge clk);
        check({tag, ".ctl"}, 32'(ctl()), 32'(e_ctl));
        check({tag, ".alu"}, 32'(bus.ALUctrl), 32'(e_alu));
        check({tag, ".rd"}, 32'(bus.rd_sel), 32'(e_rd));
        @(posedge clk);
        #1;
    endtask

    task automatic fields(input string tag, input logic [4:0] e_rs, input logic [4:0] e_rt,
                          input logic [15:0] e_imm, input logic [25:0] e_tgt);
        check({tag, ".rs"}, 32'(bus.rs), 32'(e_rs));
        check({tag, ".rt"}, 32'(bus.rt), 32'(e_rt));
        check({tag, ".imm"}, 32'(bus.imm16), 32'(e_imm));
        check({tag, ".tgt"}, 32'(bus.TargetInstr), 32'(e_tgt));
    endtask

    // Four-cycle R-type/immediate ALU instruction.
    task automatic alu4(input string tag, input logic [31:0] ins, input logic [12:0] fl,
                        input logic [12:0] ex_src, input logic [2:0] alu, input logic [4:0] rd);
        bus.Instruction = ins;
        cyc({tag, ".c1"}, fl, 3'd0, 5'd0);
        cyc({tag, ".c2"}, fl, 3'd0, 5'd0);
        cyc({tag, ".c3"}, fl | ex_src, alu, 5'd0);
        cyc({tag, ".c4"}, fl | C_PCA | C_RW, 3'd0, rd);
    endtask

    initial begin
        reset           = 1'b1;
        bus.Instruction = 32'h0;
        bus.mem_ready   = 1'b0;
        f               = 13'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.ctl", 32'(ctl()), 32'h0);
        check("reset.rd", 32'(bus.rd_sel), 32'h0);
        check("reset.tgt", 32'(bus.TargetInstr), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        bus.Instruction = 32'h00221820;
        cyc("add.c1", 13'h0, 3'd0, 5'd0);
        fields("add.f", 5'd1, 5'd2, 16'h1820, 26'h0221820);
        cyc("add.c2", 13'h0, 3'd0, 5'd0);
        cyc("add.c3", 13'h0, 3'd0, 5'd0);
        cyc("add.c4", C_PCA | C_RW, 3'd0, 5'd3);

        alu4("sub", 32'h00222822, f, 13'h0, 3'b001, 5'd5);
        alu4("slt", 32'h0022302A, f, 13'h0, 3'b010, 5'd6);
        alu4("addi", 32'h20270005, f, C_SRC, 3'b000, 5'd7);
        alu4("xori", 32'h382800FF, f, C_SRC, 3'b011, 5'd8);

        bus.Instruction = 32'h08000009;
        cyc("j.c1", 13'h0, 3'd0, 5'd0);
        fields("j.f", 5'd0, 5'd0, 16'h0009, 26'h9);
        cyc("j.c2", C_PCA | C_J, 3'd0, 5'd0);

        bus.Instruction = 32'h0C000005;
        cyc("jal.c1", 13'h0, 3'd0, 5'd0);
        cyc("jal.c2", C_PCA | C_J | C_RW | C_LNK, 3'd0, 5'd31);

        bus.Instruction = 32'h00200008;
        cyc("jr.c1", 13'h0, 3'd0, 5'd0);
        cyc("jr.c2", C_PCA | C_JR, 3'd0, 5'd0);

        bus.Instruction = 32'h14220003;
        cyc("bne.c1", 13'h0, 3'd0, 5'd0);
        fields("bne.f", 5'd1, 5'd2, 16'h0003, 26'h0220003);
        cyc("bne.c2", 13'h0, 3'd0, 5'd0);
        cyc("bne.c3", C_PCA | C_BR | C_INV, 3'b001, 5'd0);

        bus.Instruction = 32'h10220003;
        cyc("beq.c1", 13'h0, 3'd0, 5'd0);
        cyc("beq.c2", 13'h0, 3'd0, 5'd0);
        cyc("beq.c3", C_PCA | C_BR, 3'b001, 5'd0);

        bus.Instruction = 32'h8C240008;
        cyc("lw.c1", 13'h0, 3'd0, 5'd0);
        cyc("lw.c2", 13'h0, 3'd0, 5'd0);
        cyc("lw.c3", C_SRC, 3'd0, 5'd0);
        for (int i = 4; i <= 6; i++) cyc($sformatf("lw.c%0d", i), C_MR, 3'd0, 5'd0);
        bus.mem_ready = 1'b1;
        cyc("lw.c7", C_MR, 3'd0, 5'd0);
        bus.mem_ready = 1'b0;
        cyc("lw.c8", C_PCA | C_RW | C_M2R, 3'd0, 5'd4);

        bus.Instruction = 32'hAC240008;
        cyc("swto.c1", 13'h0, 3'd0, 5'd0);
        cyc("swto.c2", 13'h0, 3'd0, 5'd0);
        cyc("swto.c3", C_SRC, 3'd0, 5'd0);
        for (int i = 4; i <= 17; i++) cyc($sformatf("swto.c%0d", i), C_MW, 3'd0, 5'd0);
        cyc("swto.c18", C_MW | C_PCA | C_TO, 3'd0, 5'd0);
        f = C_TO;
        alu4("add2", 32'h00221820, f, 13'h0, 3'b000, 5'd3);

        bus.Instruction = 32'hAC240008;
        cyc("sw.c1", f, 3'd0, 5'd0);
        cyc("sw.c2", f, 3'd0, 5'd0);
        cyc("sw.c3", f | C_SRC, 3'd0, 5'd0);
        cyc("sw.c4", f | C_MW, 3'd0, 5'd0);
        bus.mem_ready = 1'b1;
        cyc("sw.c5", f | C_MW | C_PCA, 3'd0, 5'd0);
        bus.mem_ready = 1'b0;

        bus.Instruction = 32'hFC000000;
        cyc("ill.c1", f, 3'd0, 5'd0);
        cyc("ill.c2", f | C_PCA | C_ILL, 3'd0, 5'd0);
        f = C_TO | C_ILL;
        bus.Instruction = 32'h0000003F;
        cyc("illfn.c1", f, 3'd0, 5'd0);
        cyc("illfn.c2", f | C_PCA, 3'd0, 5'd0);

        bus.Instruction = 32'hAC240008;
        cyc("rstmem.c1", f, 3'd0, 5'd0);
        cyc("rstmem.c2", f, 3'd0, 5'd0);
        cyc("rstmem.c3", f | C_SRC, 3'd0, 5'd0);
        cyc("rstmem.c4", f | C_MW, 3'd0, 5'd0);
        #2;
        check("rstmem.pre", 32'(ctl()), 32'(f | C_MW));
        reset = 1'b1;
        #1;
        check("rstmem.async", 32'(ctl()), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        f = 13'h0;
        alu4("add3", 32'h00221820, f, 13'h0, 3'b000, 5'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
